// File: rtl/jelly3_video_trimmer_core.sv
// jelly3_video_trimmer_core
//   Crops a rectangular window out of a regularized AXI4-Stream video stream
//   and regenerates frame-start (tuser[0]) and line-end (tlast) for the window.
//   Window parameters are latched on every accepted frame-start beat, so a
//   reconfiguration only ever takes effect at a frame boundary.
//
// Ports
//   aresetn, aclk, aclken        : async active-low reset, clock, clock enable
//   ctl_enable                   : crop (1) or bypass (0), sampled at frame start
//   ctl_busy                     : frame in progress
//   param_x/y/width/height       : requested window
//   current_x/y/width/height     : window latched for the active frame
//   s_axi4s_*                    : input stream (tuser[0] = frame start)
//   m_axi4s_*                    : output stream, one registered stage

`timescale 1ns/1ps

module jelly3_video_trimmer_core #(
    parameter int unsigned WIDTH_BITS  = 16,
    parameter int unsigned HEIGHT_BITS = 16,
    parameter int unsigned DATA_BITS   = 24,
    parameter int unsigned USER_BITS   = 1
) (
    input  logic                   aresetn,
    input  logic                   aclk,
    input  logic                   aclken,

    input  logic                   ctl_enable,
    output logic                   ctl_busy,

    input  logic [WIDTH_BITS-1:0]  param_x,
    input  logic [HEIGHT_BITS-1:0] param_y,
    input  logic [WIDTH_BITS-1:0]  param_width,
    input  logic [HEIGHT_BITS-1:0] param_height,

    output logic [WIDTH_BITS-1:0]  current_x,
    output logic [HEIGHT_BITS-1:0] current_y,
    output logic [WIDTH_BITS-1:0]  current_width,
    output logic [HEIGHT_BITS-1:0] current_height,

    input  logic [DATA_BITS-1:0]   s_axi4s_tdata,
    input  logic [USER_BITS-1:0]   s_axi4s_tuser,
    input  logic                   s_axi4s_tlast,
    input  logic                   s_axi4s_tvalid,
    output logic                   s_axi4s_tready,

    output logic [DATA_BITS-1:0]   m_axi4s_tdata,
    output logic [USER_BITS-1:0]   m_axi4s_tuser,
    output logic                   m_axi4s_tlast,
    output logic                   m_axi4s_tvalid,
    input  logic                   m_axi4s_tready
);

    // one extra bit so origin+size never wraps
    localparam int unsigned XW = WIDTH_BITS + 1;
    localparam int unsigned YW = HEIGHT_BITS + 1;

    typedef enum logic [1:0] {
        ST_WAIT   = 2'd0,
        ST_CROP   = 2'd1,
        ST_BYPASS = 2'd2
    } state_t;

    state_t                 state_q,  state_d;
    logic                   busy_q,   busy_d;
    logic [WIDTH_BITS-1:0]  x_q,      x_d;
    logic [HEIGHT_BITS-1:0] y_q,      y_d;
    logic [WIDTH_BITS-1:0]  cur_x_q,  cur_x_d;
    logic [HEIGHT_BITS-1:0] cur_y_q,  cur_y_d;
    logic [WIDTH_BITS-1:0]  cur_w_q,  cur_w_d;
    logic [HEIGHT_BITS-1:0] cur_h_q,  cur_h_d;
    logic                   m_valid_q, m_valid_d;
    logic [DATA_BITS-1:0]   m_data_q,  m_data_d;
    logic [USER_BITS-1:0]   m_user_q,  m_user_d;
    logic                   m_last_q,  m_last_d;

    logic                   s_ready_c;
    logic                   accept_c;
    logic                   sof_c;
    logic [WIDTH_BITS-1:0]  beat_x_c;
    logic [HEIGHT_BITS-1:0] beat_y_c;
    state_t                 mode_c;
    logic [WIDTH_BITS-1:0]  win_x_c;
    logic [HEIGHT_BITS-1:0] win_y_c;
    logic [WIDTH_BITS-1:0]  win_w_c;
    logic [HEIGHT_BITS-1:0] win_h_c;
    logic [XW-1:0]          x_end_c;
    logic [YW-1:0]          y_end_c;
    logic                   in_win_c;
    logic                   first_c;
    logic                   line_end_c;
    logic                   frame_end_c;

    // handshake
    assign s_ready_c      = ~m_valid_q | m_axi4s_tready;
    assign s_axi4s_tready = s_ready_c;
    assign accept_c       = s_axi4s_tvalid & s_ready_c & aclken;
    assign sof_c          = s_axi4s_tuser[0];

    // position of the current beat; a frame start always restarts at (0,0)
    assign beat_x_c = sof_c ? '0 : x_q;
    assign beat_y_c = sof_c ? '0 : y_q;

    // a frame-start beat is judged by the mode and window it is about to latch
    assign mode_c  = sof_c ? (ctl_enable ? ST_CROP : ST_BYPASS) : state_q;
    assign win_x_c = sof_c ? param_x      : cur_x_q;
    assign win_y_c = sof_c ? param_y      : cur_y_q;
    assign win_w_c = sof_c ? param_width  : cur_w_q;
    assign win_h_c = sof_c ? param_height : cur_h_q;

    // window geometry
    assign x_end_c     = XW'(win_x_c) + XW'(win_w_c);
    assign y_end_c     = YW'(win_y_c) + YW'(win_h_c);
    assign in_win_c    = (beat_x_c >= win_x_c) && (XW'(beat_x_c) < x_end_c)
                      && (beat_y_c >= win_y_c) && (YW'(beat_y_c) < y_end_c);
    assign first_c     = (beat_x_c == win_x_c) && (beat_y_c == win_y_c);
    // x == x0+w-1 written as x+1 == x0+w so a zero width cannot underflow
    assign line_end_c  = (XW'(beat_x_c) + XW'(1)) == x_end_c;
    assign frame_end_c = (YW'(beat_y_c) + YW'(1)) >= y_end_c;

    // next-state and output stage
    always_comb begin
        state_d   = state_q;
        busy_d    = busy_q;
        x_d       = x_q;
        y_d       = y_q;
        cur_x_d   = cur_x_q;
        cur_y_d   = cur_y_q;
        cur_w_d   = cur_w_q;
        cur_h_d   = cur_h_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_user_d  = m_user_q;
        m_last_d  = m_last_q;

        if (aclken) begin
            if (m_axi4s_tready) begin
                m_valid_d = 1'b0;
            end

            if (accept_c) begin
                // position expected for the following beat, saturating
                if (s_axi4s_tlast) begin
                    x_d = '0;
                    y_d = (beat_y_c == '1) ? beat_y_c : beat_y_c + HEIGHT_BITS'(1);
                end else begin
                    x_d = (beat_x_c == '1) ? beat_x_c : beat_x_c + WIDTH_BITS'(1);
                    y_d = beat_y_c;
                end

                if (sof_c) begin
                    cur_x_d = param_x;
                    cur_y_d = param_y;
                    cur_w_d = param_width;
                    cur_h_d = param_height;
                end

                state_d = mode_c;

                case (mode_c)
                    ST_BYPASS: begin
                        m_valid_d = 1'b1;
                        m_data_d  = s_axi4s_tdata;
                        m_user_d  = s_axi4s_tuser;
                        m_last_d  = s_axi4s_tlast;
                    end
                    ST_CROP: begin
                        if (in_win_c) begin
                            m_valid_d   = 1'b1;
                            m_data_d    = s_axi4s_tdata;
                            m_user_d    = s_axi4s_tuser;
                            m_user_d[0] = first_c;
                            m_last_d    = line_end_c;
                        end
                        if (s_axi4s_tlast && frame_end_c) begin
                            state_d = ST_WAIT;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end

        busy_d = (state_d != ST_WAIT);
    end

    // state and output registers
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= ST_WAIT;
            busy_q    <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            cur_x_q   <= '0;
            cur_y_q   <= '0;
            cur_w_q   <= '0;
            cur_h_q   <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_user_q  <= '0;
            m_last_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            x_q       <= x_d;
            y_q       <= y_d;
            cur_x_q   <= cur_x_d;
            cur_y_q   <= cur_y_d;
            cur_w_q   <= cur_w_d;
            cur_h_q   <= cur_h_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_user_q  <= m_user_d;
            m_last_q  <= m_last_d;
        end
    end

    assign ctl_busy       = busy_q;
    assign current_x      = cur_x_q;
    assign current_y      = cur_y_q;
    assign current_width  = cur_w_q;
    assign current_height = cur_h_q;
    assign m_axi4s_tvalid = m_valid_q;
    assign m_axi4s_tdata  = m_data_q;
    assign m_axi4s_tuser  = m_user_q;
    assign m_axi4s_tlast  = m_last_q;

endmodule

// File: tb/tb_jelly3_video_trimmer_core.sv
// Testbench for jelly3_video_trimmer_core: directed frame scenarios with
// randomized handshakes, checked against a frame-level reference model.

`timescale 1ns/1ps

module tb_jelly3_video_trimmer_core;

    localparam int unsigned WB = 16;
    localparam int unsigned HB = 16;
    localparam int unsigned DB = 24;
    localparam int unsigned UB = 2;

    logic          aclk = 1'b0;
    logic          aresetn;
    logic          aclken;
    logic          ctl_enable;
    logic          ctl_busy;
    logic [WB-1:0] param_x, param_width, current_x, current_width;
    logic [HB-1:0] param_y, param_height, current_y, current_height;
    logic [DB-1:0] s_tdata, m_tdata;
    logic [UB-1:0] s_tuser, m_tuser;
    logic          s_tlast, s_tvalid, s_tready;
    logic          m_tlast, m_tvalid, m_tready;

    jelly3_video_trimmer_core #(
        .WIDTH_BITS (WB),
        .HEIGHT_BITS(HB),
        .DATA_BITS  (DB),
        .USER_BITS  (UB)
    ) dut (
        .aresetn       (aresetn),
        .aclk          (aclk),
        .aclken        (aclken),
        .ctl_enable    (ctl_enable),
        .ctl_busy      (ctl_busy),
        .param_x       (param_x),
        .param_y       (param_y),
        .param_width   (param_width),
        .param_height  (param_height),
        .current_x     (current_x),
        .current_y     (current_y),
        .current_width (current_width),
        .current_height(current_height),
        .s_axi4s_tdata (s_tdata),
        .s_axi4s_tuser (s_tuser),
        .s_axi4s_tlast (s_tlast),
        .s_axi4s_tvalid(s_tvalid),
        .s_axi4s_tready(s_tready),
        .m_axi4s_tdata (m_tdata),
        .m_axi4s_tuser (m_tuser),
        .m_axi4s_tlast (m_tlast),
        .m_axi4s_tvalid(m_tvalid),
        .m_axi4s_tready(m_tready)
    );

    always #5 aclk = ~aclk;

    // one input beat plus the parameter inputs presented alongside it
    typedef struct {
        logic [DB-1:0] data;
        logic [UB-1:0] user;
        logic          last;
        int            px, py, pw, ph;
        logic          en;
        int            y;
        logic          fcrop;
        int            fy, fh;
    } beat_t;

    typedef struct {
        logic [DB-1:0] data;
        logic [UB-1:0] user;
        logic          last;
    } out_t;

    beat_t in_q[$];
    out_t  exp_q[$];
    out_t  got_q[$];

    int   n_cmp = 0;
    int   n_bad = 0;
    logic exp_busy;
    int   exp_cx, exp_cw;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Builds the input beats of one frame and the output the window rules predict.
    task automatic gen_frame(input int w, input int h, input int px, input int py,
                             input int pw, input int ph, input bit en, input bit has_sof,
                             input int nbeats, input int chg_at, input int chg_px,
                             input int tag);
        int k;
        k = 0;
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                beat_t b;
                out_t  o;
                if (k < nbeats) begin
                    b.data    = DB'((tag << 16) | (y * 16 + x));
                    b.user    = '0;
                    b.user[1] = 1'($urandom_range(0, 1));
                    b.user[0] = has_sof && (x == 0) && (y == 0);
                    b.last    = (x == w - 1);
                    b.px      = (k >= chg_at) ? chg_px : px;
                    b.py      = py;
                    b.pw      = pw;
                    b.ph      = ph;
                    b.en      = en;
                    b.y       = y;
                    b.fcrop   = has_sof && en;
                    b.fy      = py;
                    b.fh      = ph;
                    in_q.push_back(b);
                    if (has_sof) begin
                        if (!en) begin
                            o.data = b.data;
                            o.user = b.user;
                            o.last = b.last;
                            exp_q.push_back(o);
                        end else if (x >= px && x < px + pw && y >= py && y < py + ph) begin
                            o.data    = b.data;
                            o.user[1] = b.user[1];
                            o.user[0] = (x == px) && (y == py);
                            o.last    = (x == px + pw - 1);
                            exp_q.push_back(o);
                        end
                    end
                    k++;
                end
            end
        end
    endtask

    // Streams in_q through the DUT with random handshakes, then compares outputs.
    task automatic run(input string name, input int vp, input int rp, input int ep);
        int   idx, tail, budget;
        bit   hold;
        out_t held, o;
        idx = 0; tail = 0; budget = 20000; hold = 1'b0;
        got_q.delete();
        while ((idx < in_q.size() || m_tvalid || tail < 3) && budget > 0) begin
            @(negedge aclk);
            check({name, " busy"},  64'(ctl_busy),      64'(exp_busy));
            check({name, " cur_x"}, 64'(current_x),     64'(exp_cx));
            check({name, " cur_w"}, 64'(current_width), 64'(exp_cw));
            if (hold) begin
                check({name, " hold valid"}, 64'(m_tvalid), 64'(1));
                check({name, " hold data"},  64'(m_tdata),  64'(held.data));
                check({name, " hold user"},  64'(m_tuser),  64'(held.user));
                check({name, " hold last"},  64'(m_tlast),  64'(held.last));
            end
            m_tready = ($urandom_range(0, 99) < rp);
            aclken   = ($urandom_range(0, 99) < ep);
            if (idx < in_q.size()) begin
                s_tdata      = in_q[idx].data;
                s_tuser      = in_q[idx].user;
                s_tlast      = in_q[idx].last;
                param_x      = WB'(in_q[idx].px);
                param_y      = HB'(in_q[idx].py);
                param_width  = WB'(in_q[idx].pw);
                param_height = HB'(in_q[idx].ph);
                ctl_enable   = in_q[idx].en;
                s_tvalid     = ($urandom_range(0, 99) < vp);
            end else begin
                s_tvalid = 1'b0;
            end
            #1;
            if (m_tvalid && m_tready && aclken) begin
                o.data = m_tdata;
                o.user = m_tuser;
                o.last = m_tlast;
                got_q.push_back(o);
            end
            if (s_tvalid && s_tready && aclken) begin
                if (in_q[idx].user[0]) begin
                    exp_busy = 1'b1;
                    exp_cx   = in_q[idx].px;
                    exp_cw   = in_q[idx].pw;
                end
                if (in_q[idx].fcrop && in_q[idx].last && (in_q[idx].y + 1 >= in_q[idx].fy + in_q[idx].fh))
                    exp_busy = 1'b0;
                idx++;
            end
            hold      = m_tvalid && !(m_tready && aclken);
            held.data = m_tdata;
            held.user = m_tuser;
            held.last = m_tlast;
            if (idx >= in_q.size()) tail++;
            budget--;
        end
        s_tvalid = 1'b0;
        check({name, " cycle budget left"}, 64'(budget > 0), 64'(1));
        check({name, " out count"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            check($sformatf("%s data[%0d]", name, i), 64'(got_q[i].data), 64'(exp_q[i].data));
            check($sformatf("%s user[%0d]", name, i), 64'(got_q[i].user), 64'(exp_q[i].user));
            check($sformatf("%s last[%0d]", name, i), 64'(got_q[i].last), 64'(exp_q[i].last));
        end
        in_q.delete();
        exp_q.delete();
    endtask

    initial begin
        aresetn = 1'b1; aclken = 1'b1; ctl_enable = 1'b0;
        param_x = '0; param_y = '0; param_width = '0; param_height = '0;
        s_tdata = '0; s_tuser = '0; s_tlast = 1'b0; s_tvalid = 1'b0; m_tready = 1'b0;
        #2 aresetn = 1'b0;
        repeat (3) @(negedge aclk);

        // reset values
        check("rst m_tvalid", 64'(m_tvalid), 64'(0));
        check("rst m_tdata",  64'(m_tdata),  64'(0));
        check("rst m_tuser",  64'(m_tuser),  64'(0));
        check("rst m_tlast",  64'(m_tlast),  64'(0));
        check("rst busy",     64'(ctl_busy), 64'(0));
        check("rst cur_x",    64'(current_x), 64'(0));
        check("rst cur_y",    64'(current_y), 64'(0));
        check("rst cur_w",    64'(current_width), 64'(0));
        check("rst cur_h",    64'(current_height), 64'(0));
        check("rst s_tready", 64'(s_tready), 64'(1));
        aresetn  = 1'b1;
        exp_busy = 1'b0; exp_cx = 0; exp_cw = 0;

        // 8x4 frame, window (2,1) 3x2, no backpressure
        gen_frame(8, 4, 2, 1, 3, 2, 1'b1, 1'b1, 1000, 1000, 0, 0);
        run("t1", 100, 100, 100);
        check("t1 count6", 64'(got_q.size()), 64'(6));
        if (got_q.size() >= 6) begin
            check("t1 first data", 64'(got_q[0].data), 64'(24'h000012));
            check("t1 first sof",  64'(got_q[0].user[0]), 64'(1));
            check("t1 beat2 data", 64'(got_q[2].data), 64'(24'h000014));
            check("t1 beat2 last", 64'(got_q[2].last), 64'(1));
            check("t1 beat3 sof",  64'(got_q[3].user[0]), 64'(0));
            check("t1 beat5 data", 64'(got_q[5].data), 64'(24'h000024));
        end
        check("t1 busy end", 64'(ctl_busy), 64'(0));

        // bypass
        gen_frame(8, 4, 2, 1, 3, 2, 1'b0, 1'b1, 1000, 1000, 0, 1);
        run("t2", 100, 100, 100);
        check("t2 count32", 64'(got_q.size()), 64'(32));

        // random frames and windows under backpressure and clock-enable gaps
        for (int f = 0; f < 10; f++) begin
            int w, h, px, py, pw, ph;
            bit en;
            w  = int'($urandom_range(1, 10));
            h  = int'($urandom_range(1, 6));
            px = int'($urandom_range(0, w));
            py = int'($urandom_range(0, h));
            pw = int'($urandom_range(0, w + 2));
            ph = int'($urandom_range(0, h + 1));
            en = ($urandom_range(0, 3) != 0);
            gen_frame(w, h, px, py, pw, ph, en, 1'b1, 1000, 1000, 0, f + 2);
        end
        run("t3", 70, 50, 90);

        // window overrunning right edge, then zero width
        gen_frame(8, 4, 6, 1, 5, 2, 1'b1, 1'b1, 1000, 1000, 0, 20);
        gen_frame(8, 4, 2, 1, 0, 2, 1'b1, 1'b1, 1000, 1000, 0, 21);
        run("t4", 80, 60, 100);
        check("t4 count4", 64'(got_q.size()), 64'(4));

        // param_x changes mid-frame, then SOF truncating a frame at beat 10
        gen_frame(8, 4, 2, 1, 3, 2, 1'b1, 1'b1, 1000, 5, 4, 22);
        gen_frame(8, 4, 4, 1, 3, 2, 1'b1, 1'b1, 1000, 1000, 0, 23);
        gen_frame(8, 4, 1, 0, 3, 2, 1'b1, 1'b1, 10, 1000, 0, 24);
        gen_frame(8, 4, 2, 1, 3, 2, 1'b1, 1'b1, 1000, 1000, 0, 25);
        run("t5", 70, 50, 100);

        // reset while an output beat is pending
        @(negedge aclk);
        aclken = 1'b1; m_tready = 1'b0; ctl_enable = 1'b0; param_x = WB'(5);
        s_tdata = 24'hABCDEF; s_tuser = 2'b01; s_tlast = 1'b0; s_tvalid = 1'b1;
        @(negedge aclk);
        s_tvalid = 1'b0;
        check("t6 pending valid", 64'(m_tvalid), 64'(1));
        check("t6 pending cur_x", 64'(current_x), 64'(5));
        #2 aresetn = 1'b0;
        #1;
        check("t6 rst valid", 64'(m_tvalid), 64'(0));
        check("t6 rst data",  64'(m_tdata),  64'(0));
        check("t6 rst busy",  64'(ctl_busy), 64'(0));
        check("t6 rst cur_x", 64'(current_x), 64'(0));
        @(negedge aclk);
        aresetn  = 1'b1;
        exp_busy = 1'b0; exp_cx = 0; exp_cw = 0;
        gen_frame(8, 4, 0, 0, 8, 4, 1'b0, 1'b0, 12, 1000, 0, 30);
        gen_frame(8, 4, 2, 1, 3, 2, 1'b1, 1'b1, 1000, 1000, 0, 31);
        run("t6", 70, 50, 100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
